bram_read_arbiter: RTL and testbench
====================================

BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the single BRAM read port.
REQ-002 Parameter ADDR_WORDS, default 1024: BRAM depth in 32-bit words, power of two.
REQ-003 Parameter LEN_BITS, default 9: width of the burst length field; max burst is 2^LEN_BITS-1 words.
REQ-004 Parameter BRAM_DELAY, default 2: BRAM read latency in clk cycles.
REQ-005 clk  in  1: single clock for all logic; BRAM_clk is driven from it.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ: per-requester burst request, level-sensitive.
REQ-008 base_addr  in  NUM_REQ x log2(ADDR_WORDS): per-requester start word index.
REQ-009 len  in  NUM_REQ x LEN_BITS: per-requester burst length in words.
REQ-010 grant  out  NUM_REQ: one-hot, marks the requester currently being served.
REQ-011 done  out  NUM_REQ: one-cycle pulse per requester when its last word is delivered.
REQ-012 rd_valid  out  1: rd_id, rd_index and rd_data are valid this cycle.
REQ-013 rd_id  out  log2(NUM_REQ): requester that owns the returned word.
REQ-014 rd_index  out  LEN_BITS: offset of the returned word within the burst, from 0.
REQ-015 rd_data  out  16: BRAM_dout[15:0] (samples occupy the low half of each word).
REQ-016 BRAM_addr 32 out, BRAM_clk 1 out, BRAM_din 32 out, BRAM_dout 32 in, BRAM_en 1 out, BRAM_rst 1 out, BRAM_we 4 out: BRAM port; BRAM_addr is a byte address.

Function
REQ-017 The arbiter SHALL be read-only: BRAM_we = 0 and BRAM_din = 0 at all times.
REQ-018 The state machine SHALL have three states: IDLE, ISSUE, DRAIN.
REQ-019 In IDLE with any req bit set, the arbiter SHALL select one requester round-robin, starting from the index after the last-granted requester (index 0 after reset), latch its base_addr and len, assert its grant bit, and go to ISSUE on the next edge.
REQ-020 In ISSUE, BRAM_en = 1 and BRAM_addr = ((base + k) mod ADDR_WORDS) * 4 for k = 0..len-1, one address per cycle; after the last address the state SHALL move to DRAIN.
REQ-021 Returned data SHALL appear on rd_valid/rd_data exactly BRAM_DELAY cycles after its address is presented, with rd_index = k and rd_id = the granted requester.
REQ-022 DRAIN SHALL hold BRAM_en = 1 until the last word returns, pulse done for the granted requester in the same cycle as the last rd_valid, clear grant, and return to IDLE.
REQ-023 A new grant SHALL NOT be issued in the cycle done pulses; the earliest next grant comes one cycle later from IDLE.
REQ-024 A latched burst SHALL run to completion even if req deasserts or base_addr/len change during it.
REQ-025 len = 0 SHALL produce a grant lasting one cycle, no BRAM reads, no rd_valid, and a done pulse on that cycle; the arbiter then returns to IDLE.
REQ-026 An address wrap past ADDR_WORDS-1 SHALL continue at word 0 without a gap.
REQ-027 A requester still asserting req after its done SHALL be re-served only after the other pending requesters (fairness).
REQ-028 BRAM_en = 0 in IDLE; rd_valid = 0 whenever no data is returning.
REQ-029 BRAM_clk SHALL equal clk combinationally.

Reset
REQ-030 While rst_n = 0: state = IDLE, grant = 0, done = 0, rd_valid = 0, rd_id = 0, rd_index = 0, rd_data = 0, BRAM_addr = 0, BRAM_en = 0, BRAM_rst = 1, round-robin pointer = 0.
REQ-031 BRAM_rst SHALL deassert on the first clk edge after rst_n rises.
REQ-032 Reset asserted mid-burst SHALL abort immediately: no further rd_valid and no done for the aborted burst.

Verification
REQ-033 Single request: req[1]=1, base=10, len=4 -> BRAM_addr 40,44,48,52 on consecutive cycles; rd_index 0..3, rd_id=1, each word 2 cycles after its address; done[1] pulses with rd_index=3.
REQ-034 Simultaneous requests: req=4'b1111 held, len=2 each -> grants in order 0,1,2,3,0; exactly one grant bit high at any time.
REQ-035 Wrap: base=1022, len=4, ADDR_WORDS=1024 -> word addresses 1022,1023,0,1 (bytes 4088,4092,0,4).
REQ-036 Zero length: req[2]=1, len=0 -> grant[2] and done[2] for one cycle, BRAM_en stays 0, no rd_valid.
REQ-037 Reset mid-burst: rst_n low at the 3rd address of a len=8 burst -> all outputs at reset values asynchronously; after release, req[0] is served first.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : bram_read_arbiter_if
// Description : Requester bus plus BRAM read port shared by the
//               bram_read_arbiter. The arbiter connects through the master
//               modport; the requesters and the BRAM connect through slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bram_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WORDS = 1024,
    parameter int LEN_BITS   = 9
);
    localparam int c_addr_w = $clog2(ADDR_WORDS);
    localparam int c_id_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0][c_addr_w-1:0]  base_addr;
    logic [NUM_REQ-1:0][LEN_BITS-1:0]  len;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                done;
    logic                              rd_valid;
    logic [c_id_w-1:0]                 rd_id;
    logic [LEN_BITS-1:0]               rd_index;
    logic [15:0]                       rd_data;

    // BRAM port (byte addressed)
    logic [31:0]                       BRAM_addr;
    logic                              BRAM_clk;
    logic [31:0]                       BRAM_din;
    logic [31:0]                       BRAM_dout;
    logic                              BRAM_en;
    logic                              BRAM_rst;
    logic [3:0]                        BRAM_we;

    modport master (
        input  req, base_addr, len, BRAM_dout,
        output grant, done, rd_valid, rd_id, rd_index, rd_data,
        output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
    );

    modport slave (
        output req, base_addr, len, BRAM_dout,
        input  grant, done, rd_valid, rd_id, rd_index, rd_data,
        input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
    );

endinterface

`default_nettype wire

// File: rtl/bram_read_arbiter.sv
//------------------------------------------------------------------------------
// Module      : bram_read_arbiter
// Description : Round-robin arbiter granting NUM_REQ burst requesters access
//               to one read-only BRAM port. A granted burst issues one word
//               address per cycle, wraps at the end of the BRAM, and returns
//               the low 16 bits of each word BRAM_DELAY cycles later, tagged
//               with requester id and burst offset. BRAM_DELAY must be >= 1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bram_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WORDS = 1024,
    parameter int LEN_BITS   = 9,
    parameter int BRAM_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_read_arbiter_if.master  bus
);

    localparam int c_addr_w = $clog2(ADDR_WORDS);
    localparam int c_id_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [c_id_w-1:0]      r_id;
    logic [c_id_w-1:0]      r_ptr;
    logic [c_addr_w-1:0]    r_word;
    logic [LEN_BITS-1:0]    r_k;
    logic [LEN_BITS-1:0]    r_last_k;
    logic                   r_en;
    logic                   r_zero;
    logic                   r_bram_rst;

    // Return pipeline: one entry per cycle of BRAM latency
    logic [BRAM_DELAY-1:0]  r_pv;
    logic [BRAM_DELAY-1:0]  r_plast;
    logic [LEN_BITS-1:0]    r_pidx [BRAM_DELAY];

    int                     w_idx;
    logic                   w_any;
    logic [c_id_w-1:0]      w_win;
    logic [c_id_w-1:0]      w_next_ptr;
    logic                   w_issue;
    logic                   w_last_ret;
    logic                   w_unused_dout;

    assign w_issue    = (r_state == ISSUE);
    assign w_last_ret = r_pv[BRAM_DELAY-1] & r_plast[BRAM_DELAY-1];

    // Round-robin pick: the first active request at or after r_ptr wins
    always_comb begin
        w_idx = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (bus.req[c_id_w'(w_idx)]) begin
                w_any = 1'b1;
                w_win = c_id_w'(w_idx);
            end
        end
    end

    // Pointer moves to the requester after the winner so it is served last next time
    always_comb begin
        w_next_ptr = (w_win == c_id_w'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    // Control FSM: latches the winning burst, walks its addresses, waits for the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_id       <= '0;
            r_ptr      <= '0;
            r_word     <= '0;
            r_k        <= '0;
            r_last_k   <= '0;
            r_en       <= 1'b0;
            r_zero     <= 1'b0;
            r_bram_rst <= 1'b1;
        end else begin
            r_bram_rst <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant  <= NUM_REQ'(1) << w_win;
                        r_id     <= w_win;
                        r_ptr    <= w_next_ptr;
                        r_word   <= bus.base_addr[w_win];
                        r_last_k <= bus.len[w_win] - 1'b1;
                        r_k      <= '0;
                        if (bus.len[w_win] == '0) begin
                            // Empty burst: one grant cycle with done, no reads
                            r_zero  <= 1'b1;
                            r_en    <= 1'b0;
                            r_state <= DRAIN;
                        end else begin
                            r_zero  <= 1'b0;
                            r_en    <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (r_k == r_last_k) begin
                        r_state <= DRAIN;
                    end else begin
                        r_k    <= r_k + 1'b1;
                        // Word index wraps to 0 naturally at ADDR_WORDS
                        r_word <= r_word + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_last_ret || r_zero) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_en    <= 1'b0;
                        r_zero  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Delay line tagging each issued address with its offset and last-word flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv    <= '0;
            r_plast <= '0;
            for (int i = 0; i < BRAM_DELAY; i++) begin
                r_pidx[i] <= '0;
            end
        end else begin
            r_pv[0]    <= w_issue;
            r_plast[0] <= w_issue && (r_k == r_last_k);
            r_pidx[0]  <= r_k;
            for (int i = 1; i < BRAM_DELAY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_plast[i] <= r_plast[i-1];
                r_pidx[i]  <= r_pidx[i-1];
            end
        end
    end

    // Only the low half of each BRAM word carries sample data
    assign w_unused_dout = ^bus.BRAM_dout[31:16];

    assign bus.grant     = r_grant;
    assign bus.done      = r_grant & {NUM_REQ{w_last_ret | r_zero}};
    assign bus.rd_valid  = r_pv[BRAM_DELAY-1];
    assign bus.rd_id     = r_id;
    assign bus.rd_index  = r_pidx[BRAM_DELAY-1];
    assign bus.rd_data   = r_pv[BRAM_DELAY-1] ? bus.BRAM_dout[15:0] : 16'h0000;

    assign bus.BRAM_addr = {{(30 - c_addr_w){1'b0}}, r_word, 2'b00};
    assign bus.BRAM_clk  = clk;
    assign bus.BRAM_din  = 32'h0000_0000;
    assign bus.BRAM_we   = 4'b0000;
    assign bus.BRAM_en   = r_en;
    assign bus.BRAM_rst  = r_bram_rst;

endmodule

`default_nettype wire

// File: tb/tb_bram_read_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_bram_read_arbiter
// Description : Self-checking bench for bram_read_arbiter with a BRAM model,
//               a beat scoreboard and a table of single-requester bursts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bram_read_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WORDS = 1024;
    localparam int LEN_BITS   = 9;
    localparam int BRAM_DELAY = 2;

    logic clk = 1'b0;
    logic rst_n;

    bram_read_arbiter_if #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WORDS (ADDR_WORDS),
        .LEN_BITS   (LEN_BITS)
    ) bus ();

    bram_read_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WORDS (ADDR_WORDS),
        .LEN_BITS   (LEN_BITS),
        .BRAM_DELAY (BRAM_DELAY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        int          idx;
        int          byte_addr;
        logic [15:0] data;
        bit          last;
    } beat_t;

    typedef struct {
        int id;
        int base;
        int len;
        bit scramble;
        int exp_first_byte;
        int exp_last_byte;
    } vec_t;

    beat_t sb[$];
    int    got_grants[$];
    bit    zl_mode = 1'b0;
    int    first_addr_seen;
    int    last_addr_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input int w);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(w * 37 + 11);
        hi = 16'(w) ^ 16'hA5A5;
        return {hi, lo};
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    // BRAM model: data for an address presented in cycle t is on dout in cycle t+BRAM_DELAY
    logic [31:0] bpipe [BRAM_DELAY];
    always @(posedge clk) begin
        bpipe[0] <= bus.BRAM_en ? mem_word(int'(bus.BRAM_addr[11:2])) : 32'h0;
        for (int i = 1; i < BRAM_DELAY; i++) begin
            bpipe[i] <= bpipe[i-1];
        end
    end
    assign bus.BRAM_dout = bpipe[BRAM_DELAY-1];

    task automatic push_burst(input int id, input int base, input int len);
        beat_t       b;
        logic [31:0] d;
        int          w;
        for (int k = 0; k < len; k++) begin
            w           = (base + k) % ADDR_WORDS;
            d           = mem_word(w);
            b.id        = id;
            b.idx       = k;
            b.byte_addr = w * 4;
            b.data      = d[15:0];
            b.last      = (k == len - 1);
            sb.push_back(b);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard comparison of returned beats
    logic [31:0]         ahist [BRAM_DELAY];
    logic                ehist [BRAM_DELAY];
    logic [NUM_REQ-1:0]  prev_grant = '0;
    always @(negedge clk) begin
        automatic beat_t e;
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("read_only", 32'(bus.BRAM_we == 4'd0 && bus.BRAM_din == 32'd0), 32'd1);
        if (bus.rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: rd_id %0d rd_index %0d, expected no beat (t=%0t)",
                         bus.rd_id, bus.rd_index, $time);
            end else begin
                e = sb.pop_front();
                check("rd_id", 32'(bus.rd_id), 32'(e.id));
                check("rd_index", 32'(bus.rd_index), 32'(e.idx));
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                check("addr_latency", ahist[BRAM_DELAY-1], 32'(e.byte_addr));
                check("en_latency", 32'(ehist[BRAM_DELAY-1]), 32'd1);
                check("done_on_beat", 32'(bus.done), e.last ? (32'd1 << e.id) : 32'd0);
                if (e.idx == 0) first_addr_seen <= int'(ahist[BRAM_DELAY-1]);
                if (e.last) last_addr_seen <= int'(ahist[BRAM_DELAY-1]);
            end
        end else if (!zl_mode) begin
            check("done_without_beat", 32'(bus.done), 32'd0);
        end
        if (bus.grant != '0 && prev_grant == '0) begin
            got_grants.push_back(onehot_idx(bus.grant));
        end
        prev_grant <= bus.grant;
        ahist[0]   <= bus.BRAM_addr;
        ehist[0]   <= bus.BRAM_en;
        for (int i = 1; i < BRAM_DELAY; i++) begin
            ahist[i] <= ahist[i-1];
            ehist[i] <= ehist[i-1];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c;
        c = 0;
        while (got_grants.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("grant_timeout", 32'(got_grants.size() >= n), 32'd1);
    endtask

    task automatic wait_sb_empty(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_rd_id"}, 32'(bus.rd_id), 32'd0);
        check({tag, "_rd_index"}, 32'(bus.rd_index), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        check({tag, "_bram_addr"}, bus.BRAM_addr, 32'd0);
        check({tag, "_bram_en"}, 32'(bus.BRAM_en), 32'd0);
        check({tag, "_bram_rst"}, 32'(bus.BRAM_rst), 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("bram_rst_before_edge", 32'(bus.BRAM_rst), 32'd1);
        tick(1);
        check("bram_rst_after_edge", 32'(bus.BRAM_rst), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   rr_exp[5];
        bit   seen;
        bit   en_seen;
        bit   rv_seen;
        int   gcount;

        bus.req       = '0;
        bus.base_addr = '0;
        bus.len       = '0;

        // Power-on reset, asserted asynchronously before any clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        tick(2);
        release_reset();

        // Four simultaneous requesters, two words each: strict rotation from 0
        rr_exp = '{0, 1, 2, 3, 0};
        got_grants.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.base_addr[i] = 10'(100 * i + 3);
            bus.len[i]       = 9'd2;
        end
        for (int i = 0; i < 5; i++) push_burst(rr_exp[i], 100 * rr_exp[i] + 3, 2);
        bus.req = 4'b1111;
        wait_grants(5, 200);
        bus.req = 4'b0000;
        wait_sb_empty(200);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 32'((got_grants.size() > i) ? got_grants[i] : -1), 32'(rr_exp[i]));
        end

        // Single-requester bursts, including wraps and mid-burst input changes
        vecs[0] = '{1,   10,  4, 1'b0, 40,   52};
        vecs[1] = '{3, 1022,  4, 1'b0, 4088, 4};
        vecs[2] = '{0, 1023,  2, 1'b1, 4092, 0};
        vecs[3] = '{2,  500,  3, 1'b1, 2000, 2008};
        vecs[4] = '{1,    0,  1, 1'b0, 0,    0};
        vecs[5] = '{0,    7, 17, 1'b0, 28,   92};
        foreach (vecs[v]) begin
            got_grants.delete();
            bus.base_addr[vecs[v].id] = 10'(vecs[v].base);
            bus.len[vecs[v].id]       = 9'(vecs[v].len);
            push_burst(vecs[v].id, vecs[v].base, vecs[v].len);
            bus.req[vecs[v].id] = 1'b1;
            if (vecs[v].scramble) begin
                wait_grants(1, 50);
                bus.base_addr[vecs[v].id] = 10'd777;
                bus.len[vecs[v].id]       = 9'd5;
            end
            wait_sb_empty(300);
            bus.req = '0;
            tick(3);
            check("vec_grant_count", 32'(got_grants.size()), 32'd1);
            check("vec_grant_id", 32'((got_grants.size() > 0) ? got_grants[0] : -1), 32'(vecs[v].id));
            check("vec_first_addr", 32'(first_addr_seen), 32'(vecs[v].exp_first_byte));
            check("vec_last_addr", 32'(last_addr_seen), 32'(vecs[v].exp_last_byte));
        end

        // Zero-length burst: one grant cycle carrying done, no BRAM activity
        zl_mode = 1'b1;
        bus.base_addr[2] = 10'd33;
        bus.len[2]       = 9'd0;
        bus.req[2]       = 1'b1;
        seen    = 1'b0;
        en_seen = 1'b0;
        rv_seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            en_seen |= bus.BRAM_en;
            rv_seen |= bus.rd_valid;
            if (bus.grant[2]) begin
                seen = 1'b1;
                check("zl_grant_value", 32'(bus.grant), 32'd4);
                check("zl_done_with_grant", 32'(bus.done), 32'd4);
            end
        end
        check("zl_grant_seen", 32'(seen), 32'd1);
        tick(1);
        bus.req = '0;
        gcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            en_seen |= bus.BRAM_en;
            rv_seen |= bus.rd_valid;
            if (bus.grant != '0 || bus.done != '0) gcount++;
        end
        check("zl_single_cycle", 32'(gcount), 32'd0);
        check("zl_no_bram_en", 32'(en_seen), 32'd0);
        check("zl_no_rd_valid", 32'(rv_seen), 32'd0);
        zl_mode = 1'b0;
        tick(1);

        // Reset on the third address of an 8-word burst aborts it
        bus.base_addr[1] = 10'd200;
        bus.len[1]       = 9'd8;
        push_burst(1, 200, 8);
        bus.req = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.BRAM_en && bus.BRAM_addr == 32'd808) seen = 1'b1;
        end
        check("rst_third_addr_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check_reset_outputs("mid_burst");
        tick(3);
        check_reset_outputs("held_reset");

        // After release the pointer restarts at 0, then requester 1 follows
        got_grants.delete();
        bus.base_addr[0] = 10'd300;
        bus.len[0]       = 9'd2;
        bus.base_addr[1] = 10'd400;
        bus.len[1]       = 9'd3;
        push_burst(0, 300, 2);
        push_burst(1, 400, 3);
        bus.req = 4'b0011;
        release_reset();
        wait_grants(2, 100);
        bus.req = '0;
        wait_sb_empty(200);
        tick(3);
        check("post_rst_first", 32'((got_grants.size() > 0) ? got_grants[0] : -1), 32'd0);
        check("post_rst_second", 32'((got_grants.size() > 1) ? got_grants[1] : -1), 32'd1);
        check("post_rst_count", 32'(got_grants.size()), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
